// File: rtl/seq_detect_pkg.sv
// Shared types and reset constants for the parametrised sequence detector.
package seq_detect_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    // Reset configuration reproduces the legacy fixed 4-bit 1011 detector.
    localparam logic [3:0] DEF_PATTERN = 4'b1011;
    localparam int         DEF_LEN     = 4;
    localparam logic       DEF_OVERLAP = 1'b1;

endpackage

// File: rtl/seq_detect_param_sat_counter.sv
// Saturating up-counter; clear takes priority over increment.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    // Count up to all-ones and hold there until cleared.
    always_ff @(posedge clk) begin
        if (reset || clr)
            count <= '0;
        else if (inc && (count != '1))
            count <= count + W'(1);
    end

endmodule

// File: rtl/seq_detect_param.sv
// Serial sequence detector with a runtime-programmable pattern of 1..MAX_LEN
// bits, overlapping or non-overlapping, plus a saturating hit counter.
module seq_detect_param
    import seq_detect_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = $clog2(MAX_LEN + 1),
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_we,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               in_valid,
    input  logic               x,
    input  logic               cnt_clr,
    output logic               match,
    output logic [CNT_W-1:0]   hit_count,
    output logic               cfg_err
);

    localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);

    state_t             state, state_next;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               ovl_q, ovl_d;
    logic [MAX_LEN-1:0] hist, hist_d;
    logic [LEN_W-1:0]   fill, fill_d;
    logic               match_d, err_d, hit;

    logic [MAX_LEN-1:0] shifted;
    logic [LEN_W-1:0]   fill_inc;
    logic [MAX_LEN:0]   mask_w;
    logic [MAX_LEN-1:0] len_mask;
    logic               len_ok, hit_cond;

    // Candidate history/fill for this bit, and the masked compare against it.
    always_comb begin
        shifted  = {hist[MAX_LEN-2:0], x};
        fill_inc = (fill == MAX_L) ? fill : fill + LEN_W'(1);
        mask_w   = ((MAX_LEN+1)'(1) << len_q) - (MAX_LEN+1)'(1);
        len_mask = mask_w[MAX_LEN-1:0];
        hit_cond = (fill_inc >= len_q) && (((shifted ^ pat_q) & len_mask) == '0);
        len_ok   = (cfg_len != '0) && (cfg_len <= MAX_L);
    end

    // Next-state logic: config writes preempt data; FLUSH wipes history for one cycle.
    always_comb begin
        state_next = state;
        pat_d      = pat_q;
        len_d      = len_q;
        ovl_d      = ovl_q;
        hist_d     = hist;
        fill_d     = fill;
        match_d    = 1'b0;
        err_d      = 1'b0;
        hit        = 1'b0;
        if (cfg_we) begin
            // The data bit presented alongside a config write is dropped.
            if (len_ok) begin
                pat_d      = cfg_pattern;
                len_d      = cfg_len;
                ovl_d      = cfg_overlap;
                state_next = FLUSH;
            end else begin
                err_d = 1'b1;
            end
        end else begin
            case (state)
                FLUSH: begin
                    hist_d     = '0;
                    fill_d     = '0;
                    state_next = RUN;
                end
                default: begin
                    if (in_valid) begin
                        hist_d = shifted;
                        fill_d = fill_inc;
                        if (hit_cond) begin
                            match_d = 1'b1;
                            hit     = 1'b1;
                            // Non-overlap: demand len_q fresh bits before the next hit.
                            if (!ovl_q)
                                fill_d = '0;
                        end
                    end
                end
            endcase
        end
    end

    // State, configuration, history and registered pulse outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= RUN;
            pat_q   <= MAX_LEN'(DEF_PATTERN);
            len_q   <= LEN_W'(DEF_LEN);
            ovl_q   <= DEF_OVERLAP;
            hist    <= '0;
            fill    <= '0;
            match   <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            state   <= state_next;
            pat_q   <= pat_d;
            len_q   <= len_d;
            ovl_q   <= ovl_d;
            hist    <= hist_d;
            fill    <= fill_d;
            match   <= match_d;
            cfg_err <= err_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_hit_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (hit),
        .clr   (cnt_clr),
        .count (hit_count)
    );

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param; a second instance with a 2-bit
// counter shares the stimulus to exercise saturation.
module tb_seq_detect_param;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cfg_we = 1'b0;
    logic [7:0] cfg_pattern = '0;
    logic [3:0] cfg_len = '0;
    logic       cfg_overlap = 1'b0;
    logic       in_valid = 1'b0;
    logic       x = 1'b0;
    logic       cnt_clr = 1'b0;
    logic       match, cfg_err, match2, cfg_err2;
    logic [7:0] hit_count;
    logic [1:0] hit_count2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_detect_param #(.MAX_LEN(8), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .in_valid(in_valid), .x(x),
        .cnt_clr(cnt_clr), .match(match), .hit_count(hit_count), .cfg_err(cfg_err)
    );

    seq_detect_param #(.MAX_LEN(8), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .in_valid(in_valid), .x(x),
        .cnt_clr(cnt_clr), .match(match2), .hit_count(hit_count2), .cfg_err(cfg_err2)
    );

    task automatic send_bit(input logic b, output logic m);
        @(negedge clk); in_valid = 1'b1; x = b;
        @(posedge clk); #1; in_valid = 1'b0; m = match;
    endtask

    task automatic gap(output logic m);
        @(negedge clk); in_valid = 1'b0;
        @(posedge clk); #1; m = match;
    endtask

    task automatic do_reset();
        @(negedge clk); reset = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1; reset = 1'b0;
    endtask

    task automatic clear_cnt();
        @(negedge clk); cnt_clr = 1'b1;
        @(posedge clk); #1; cnt_clr = 1'b0;
    endtask

    task automatic do_cfg(input logic [7:0] p, input logic [3:0] l, input logic o,
                          input logic iv, input logic b);
        @(negedge clk); cfg_we = 1'b1; cfg_pattern = p; cfg_len = l; cfg_overlap = o;
        in_valid = iv; x = b;
        @(posedge clk); #1; cfg_we = 1'b0; in_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (match !== 1'b0 || hit_count !== 8'd0 || cfg_err !== 1'b0) begin
            $display("FAIL reset: match=%b hit_count=%0d cfg_err=%b want 0/0/0", match, hit_count, cfg_err);
            errors++;
        end
        checks++;
        if (match2 !== 1'b0 || hit_count2 !== 2'd0 || cfg_err2 !== 1'b0) begin
            $display("FAIL reset_dut2: match=%b hit_count=%0d cfg_err=%b want 0/0/0", match2, hit_count2, cfg_err2);
            errors++;
        end
    endtask

    task automatic test_default();
        logic [6:0] bits = 7'b1011011;
        logic [6:0] exp  = 7'b0001001;
        logic m;
        for (int i = 6; i >= 0; i--) begin
            send_bit(bits[i], m);
            checks++;
            if (m !== exp[i]) begin
                $display("FAIL default_bit%0d: match=%b want %b", 6 - i, m, exp[i]);
                errors++;
            end
        end
        checks++;
        if (hit_count !== 8'd2) begin
            $display("FAIL default_count: hit_count=%0d want 2", hit_count);
            errors++;
        end
    endtask

    task automatic test_nonoverlap();
        logic [6:0] exp_n = 7'b0010010;
        logic [6:0] exp_o = 7'b0011111;
        logic m;
        do_cfg(8'b111, 4'd3, 1'b0, 1'b0, 1'b0);
        gap(m);
        clear_cnt();
        for (int i = 6; i >= 0; i--) begin
            send_bit(1'b1, m);
            checks++;
            if (m !== exp_n[i]) begin
                $display("FAIL nonovl_bit%0d: match=%b want %b", 6 - i, m, exp_n[i]);
                errors++;
            end
        end
        checks++;
        if (hit_count !== 8'd2) begin
            $display("FAIL nonovl_count: hit_count=%0d want 2", hit_count);
            errors++;
        end
        do_cfg(8'b111, 4'd3, 1'b1, 1'b0, 1'b0);
        gap(m);
        clear_cnt();
        for (int i = 6; i >= 0; i--) begin
            send_bit(1'b1, m);
            checks++;
            if (m !== exp_o[i]) begin
                $display("FAIL ovl_bit%0d: match=%b want %b", 6 - i, m, exp_o[i]);
                errors++;
            end
        end
        checks++;
        if (hit_count !== 8'd5) begin
            $display("FAIL ovl_count: hit_count=%0d want 5", hit_count);
            errors++;
        end
        checks++;
        if (hit_count2 !== 2'd3) begin
            $display("FAIL ovl_count_sat: hit_count=%0d want 3", hit_count2);
            errors++;
        end
    endtask

    task automatic test_gaps();
        logic [7:0] bits = 8'hA5;
        logic m;
        do_cfg(8'hA5, 4'd8, 1'b0, 1'b0, 1'b0);
        gap(m);
        for (int i = 7; i >= 0; i--) begin
            send_bit(bits[i], m);
            checks++;
            if (m !== (i == 0)) begin
                $display("FAIL gaps_bit%0d: match=%b want %b", 7 - i, m, (i == 0));
                errors++;
            end
            gap(m);
            checks++;
            if (m !== 1'b0) begin
                $display("FAIL gaps_idle%0d: match=%b want 0", 7 - i, m);
                errors++;
            end
        end
    endtask

    task automatic test_cfg_err();
        logic [7:0] bits = 8'hA5;
        logic m;
        do_cfg(8'hFF, 4'd0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (cfg_err !== 1'b1) begin
            $display("FAIL cfg_len0_err: cfg_err=%b want 1", cfg_err);
            errors++;
        end
        gap(m);
        checks++;
        if (cfg_err !== 1'b0) begin
            $display("FAIL cfg_err_pulse: cfg_err=%b want 0", cfg_err);
            errors++;
        end
        // No flush on reject: the old A5 pattern is detected right away.
        for (int i = 7; i >= 0; i--) begin
            send_bit(bits[i], m);
            checks++;
            if (m !== (i == 0)) begin
                $display("FAIL cfg_keep_bit%0d: match=%b want %b", 7 - i, m, (i == 0));
                errors++;
            end
        end
        do_cfg(8'hFF, 4'd9, 1'b1, 1'b0, 1'b0);
        checks++;
        if (cfg_err !== 1'b1) begin
            $display("FAIL cfg_len9_err: cfg_err=%b want 1", cfg_err);
            errors++;
        end
    endtask

    task automatic test_cfg_with_valid();
        logic [3:0] bits = 4'b0101;
        logic [3:0] exp  = 4'b0001;
        logic m;
        do_cfg(8'b101, 4'd3, 1'b1, 1'b1, 1'b1);
        checks++;
        if (cfg_err !== 1'b0 || match !== 1'b0) begin
            $display("FAIL cfgv_accept: cfg_err=%b match=%b want 0/0", cfg_err, match);
            errors++;
        end
        // This bit lands on the FLUSH cycle and must be discarded.
        send_bit(1'b1, m);
        checks++;
        if (m !== 1'b0) begin
            $display("FAIL cfgv_flush: match=%b want 0", m);
            errors++;
        end
        for (int i = 3; i >= 0; i--) begin
            send_bit(bits[i], m);
            checks++;
            if (m !== exp[i]) begin
                $display("FAIL cfgv_bit%0d: match=%b want %b", 3 - i, m, exp[i]);
                errors++;
            end
        end
    endtask

    task automatic test_counter();
        logic m;
        do_cfg(8'b1, 4'd1, 1'b1, 1'b0, 1'b0);
        gap(m);
        clear_cnt();
        for (int i = 0; i < 5; i++) begin
            send_bit(1'b1, m);
            checks++;
            if (m !== 1'b1) begin
                $display("FAIL b2b_bit%0d: match=%b want 1", i, m);
                errors++;
            end
        end
        checks++;
        if (hit_count !== 8'd5 || hit_count2 !== 2'd3) begin
            $display("FAIL cnt_sat: hit_count=%0d/%0d want 5/3", hit_count, hit_count2);
            errors++;
        end
        @(negedge clk); cnt_clr = 1'b1; in_valid = 1'b1; x = 1'b1;
        @(posedge clk); #1; cnt_clr = 1'b0; in_valid = 1'b0;
        checks++;
        if (match !== 1'b1 || hit_count !== 8'd0 || hit_count2 !== 2'd0) begin
            $display("FAIL clr_vs_hit: match=%b hit_count=%0d/%0d want 1/0/0", match, hit_count, hit_count2);
            errors++;
        end
    endtask

    task automatic test_reset_mid();
        logic [2:0] pre  = 3'b101;
        logic [3:0] bits = 4'b1011;
        logic [3:0] exp  = 4'b0001;
        logic m;
        do_reset();
        for (int i = 2; i >= 0; i--) send_bit(pre[i], m);
        do_reset();
        checks++;
        if (match !== 1'b0 || hit_count !== 8'd0) begin
            $display("FAIL mid_reset: match=%b hit_count=%0d want 0/0", match, hit_count);
            errors++;
        end
        for (int i = 3; i >= 0; i--) begin
            send_bit(bits[i], m);
            checks++;
            if (m !== exp[i]) begin
                $display("FAIL mid_bit%0d: match=%b want %b", 3 - i, m, exp[i]);
                errors++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_default();
        test_nonoverlap();
        test_gaps();
        test_cfg_err();
        test_cfg_with_valid();
        test_counter();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
